fir_hls_div_28s_12ns_16_seq: RTL and testbench
==============================================

FIR_HLS_DIV_28S_12NS_16_SEQ -- requirements
Module: fir_hls_div_28s_12ns_16_seq

Interface
REQ-001 SHALL provide parameter DIVIDEND_WIDTH, default 28, signed dividend width.
REQ-002 SHALL provide parameter DIVISOR_WIDTH, default 12, unsigned divisor width.
REQ-003 SHALL provide parameter QUOTIENT_WIDTH, default 16, signed quotient width.
REQ-004 SHALL have ap_clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have ap_rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-006 SHALL have start  input  1  request; sampled only when busy=0.
REQ-007 SHALL have din0  input  DIVIDEND_WIDTH  dividend, two's complement.
REQ-008 SHALL have din1  input  DIVISOR_WIDTH  divisor, unsigned (zero-extended).
REQ-009 SHALL have busy  output  1  high from accept edge until result edge.
REQ-010 SHALL have dout_vld  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have dout  output  QUOTIENT_WIDTH  signed quotient, truncated toward zero, saturated.
REQ-012 SHALL have dout_rem  output  DIVISOR_WIDTH+1  signed remainder, sign of dividend.
REQ-013 SHALL have ovf  output  1  quotient saturated, valid with dout_vld, held.
REQ-014 SHALL have div_zero  output  1  divisor was zero, valid with dout_vld, held.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE.
REQ-016 IDLE, start=1 at edge N: latch |din0| (DIVIDEND_WIDTH-bit unsigned), dividend sign, din1, zero-check; go CALC, iteration counter=0.
REQ-017 CALC: one restoring shift-subtract quotient bit per edge, MSB first; after DIVIDEND_WIDTH iterations go FIX.
REQ-018 FIX edge (N+DIVIDEND_WIDTH+1): apply sign, saturate, register dout/dout_rem/ovf/div_zero, dout_vld=1 for following cycle; go IDLE.
REQ-019 Latency constant: dout_vld high in cycle after edge N+29 for defaults, independent of operands incl. divisor zero.
REQ-020 busy = (state != IDLE); start while busy SHALL be ignored, no queuing.
REQ-021 Quotient outside [-2^(QW-1), 2^(QW-1)-1] SHALL clamp to nearest bound and set ovf=1.
REQ-022 din1=0: dout = max positive if din0>=0, most negative if din0<0; dout_rem=0; div_zero=1; ovf=0.
REQ-023 din0 = -2^(DIVIDEND_WIDTH-1) SHALL be handled exactly via unsigned magnitude.
REQ-024 dout, dout_rem, ovf, div_zero SHALL hold until next FIX edge.
REQ-025 start asserted in the FIX cycle SHALL be ignored; accepted next IDLE cycle (back-to-back period = 30 cycles).

Reset
REQ-026 ap_rst=1 SHALL force IDLE, counter 0, busy=0, dout_vld=0, dout=0, dout_rem=0, ovf=0, div_zero=0 immediately, no clock needed.
REQ-027 Reset during CALC/FIX SHALL abort; no dout_vld pulse for that operation.
REQ-028 First start SHALL be accepted on first rising edge after ap_rst deasserts.

Configuration
REQ-029 Macro FIR_HLS_DIV_REM_EN defined: dout_rem computed per REQ-012.
REQ-030 Macro undefined: dout_rem port retained, driven constant 0, remainder sign-fix logic removed; quotient behaviour and latency unchanged.

Verification
REQ-031 din0=1000, din1=7, start -> after 29-cycle latency dout=142, dout_rem=6, ovf=0, div_zero=0, single vld pulse.
REQ-032 din0=-1000, din1=7 -> dout=-142, dout_rem=-6; with FIR_HLS_DIV_REM_EN undefined dout_rem=0.
REQ-033 din0=134217727, din1=1 -> dout=32767, ovf=1; din0=-134217728, din1=4095 -> dout=-32768, ovf=1.
REQ-034 din0=5, din1=0 -> dout=32767, div_zero=1; din0=-5, din1=0 -> dout=-32768, div_zero=1; latency still 29.
REQ-035 start pulsed 10 cycles into CALC with new operands -> ignored, first result unchanged; ap_rst mid-CALC -> busy=0 at once, no dout_vld, outputs 0.

Source files
------------

// File: rtl/fir_hls_div_28s_12ns_16_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_hls_div_28s_12ns_16_seq_if
// Brief    : Request/result bundle for the sequential signed divider.
// Revision : 1.0
// ============================================================================
interface fir_hls_div_28s_12ns_16_seq_if #(
    parameter int DIVIDEND_WIDTH = 28,
    parameter int DIVISOR_WIDTH  = 12,
    parameter int QUOTIENT_WIDTH = 16
);
    logic                         start;
    logic [DIVIDEND_WIDTH-1:0]    din0;
    logic [DIVISOR_WIDTH-1:0]     din1;
    logic                         busy;
    logic                         dout_vld;
    logic [QUOTIENT_WIDTH-1:0]    dout;
    logic [DIVISOR_WIDTH:0]       dout_rem;
    logic                         ovf;
    logic                         div_zero;

    modport master (
        output start, din0, din1,
        input  busy, dout_vld, dout, dout_rem, ovf, div_zero
    );

    modport slave (
        input  start, din0, din1,
        output busy, dout_vld, dout, dout_rem, ovf, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/fir_hls_div_28s_12ns_16_seq.sv
`default_nettype none
// ============================================================================
// Module   : fir_hls_div_28s_12ns_16_seq
// Brief    : Fixed-latency restoring divider, signed/unsigned -> saturated
//            signed quotient. FIR_HLS_DIV_REM_EN enables the signed remainder.
// Revision : 1.0
// ============================================================================
module fir_hls_div_28s_12ns_16_seq #(
    parameter int DIVIDEND_WIDTH = 28,
    parameter int DIVISOR_WIDTH  = 12,
    parameter int QUOTIENT_WIDTH = 16
) (
    input wire ap_clk,
    input wire ap_rst,
    fir_hls_div_28s_12ns_16_seq_if.slave bus
);
    localparam int c_CW = $clog2(DIVIDEND_WIDTH + 1);
    localparam int c_RW = DIVISOR_WIDTH + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIVIDEND_WIDTH - 1);
    localparam logic [QUOTIENT_WIDTH-1:0] c_QMAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
    localparam logic [QUOTIENT_WIDTH-1:0] c_QMIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};
    localparam logic [DIVIDEND_WIDTH-1:0] c_POS_LIM =
        {{(DIVIDEND_WIDTH-QUOTIENT_WIDTH+1){1'b0}}, {(QUOTIENT_WIDTH-1){1'b1}}};
    localparam logic [DIVIDEND_WIDTH-1:0] c_NEG_LIM =
        {{(DIVIDEND_WIDTH-QUOTIENT_WIDTH){1'b0}}, 1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [c_CW-1:0]             r_cnt;
    logic [DIVIDEND_WIDTH-1:0]   r_quo;
    logic [DIVISOR_WIDTH-1:0]    r_rem;
    logic [DIVISOR_WIDTH-1:0]    r_div;
    logic                        r_neg;
    logic                        r_zero;
    logic [QUOTIENT_WIDTH-1:0]   r_dout;
    logic                        r_ovf;
    logic                        r_dz;
    logic                        r_vld;

    logic [DIVIDEND_WIDTH-1:0]   w_abs;
    logic [c_RW-1:0]             w_shift;
    logic [c_RW-1:0]             w_diff;
    logic                        w_ge;
    logic [QUOTIENT_WIDTH-1:0]   w_dout;
    logic                        w_ovf;

    // Magnitude of the most negative dividend fits exactly in the unsigned width.
    assign w_abs   = bus.din0[DIVIDEND_WIDTH-1] ? ('0 - bus.din0) : bus.din0;
    assign w_shift = {r_rem, r_quo[DIVIDEND_WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = (w_shift >= {1'b0, r_div});

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_CALC;
            S_CALC:  if (r_cnt == c_LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Sign application and clamping of the unsigned quotient magnitude.
    always_comb begin
        w_dout = r_quo[QUOTIENT_WIDTH-1:0];
        w_ovf  = 1'b0;
        if (r_zero) begin
            w_dout = r_neg ? c_QMIN : c_QMAX;
        end else if (!r_neg && (r_quo > c_POS_LIM)) begin
            w_dout = c_QMAX;
            w_ovf  = 1'b1;
        end else if (r_neg && (r_quo > c_NEG_LIM)) begin
            w_dout = c_QMIN;
            w_ovf  = 1'b1;
        end else if (r_neg) begin
            w_dout = '0 - r_quo[QUOTIENT_WIDTH-1:0];
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_neg  <= 1'b0;
            r_zero <= 1'b0;
            r_dout <= '0;
            r_ovf  <= 1'b0;
            r_dz   <= 1'b0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_quo  <= w_abs;
                        r_rem  <= '0;
                        r_div  <= bus.din1;
                        r_neg  <= bus.din0[DIVIDEND_WIDTH-1];
                        r_zero <= (bus.din1 == '0);
                        r_cnt  <= '0;
                    end
                end
                S_CALC: begin
                    r_quo <= {r_quo[DIVIDEND_WIDTH-2:0], w_ge};
                    r_rem <= DIVISOR_WIDTH'(w_ge ? w_diff : w_shift);
                    r_cnt <= r_cnt + c_CW'(1);
                end
                S_FIX: begin
                    r_dout <= w_dout;
                    r_ovf  <= w_ovf;
                    r_dz   <= r_zero;
                    r_vld  <= 1'b1;
                    r_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef FIR_HLS_DIV_REM_EN
    logic [c_RW-1:0] r_rem_o;
    logic [c_RW-1:0] w_rem_fix;

    always_comb begin
        w_rem_fix = {1'b0, r_rem};
        if (r_zero)     w_rem_fix = '0;
        else if (r_neg) w_rem_fix = '0 - {1'b0, r_rem};
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)                r_rem_o <= '0;
        else if (r_state == S_FIX) r_rem_o <= w_rem_fix;
    end

    assign bus.dout_rem = r_rem_o;
`else
    assign bus.dout_rem = '0;
`endif

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.dout_vld = r_vld;
    assign bus.dout     = r_dout;
    assign bus.ovf      = r_ovf;
    assign bus.div_zero = r_dz;
endmodule
`default_nettype wire

// File: tb/tb_fir_hls_div_28s_12ns_16_seq.sv
`timescale 1ns/1ps
// Bench for the sequential divider: directed table, random operands against
// a plain-arithmetic model, and handshake/reset corner sequences.
module tb_fir_hls_div_28s_12ns_16_seq;
    localparam int DW = 28;
    localparam int VW = 12;
    localparam int QW = 16;
    localparam longint QMAX = (64'sd1 <<< (QW - 1)) - 1;
    localparam longint QMIN = -(64'sd1 <<< (QW - 1));

    logic ap_clk = 1'b0;
    logic ap_rst;
    always #5 ap_clk = ~ap_clk;

    fir_hls_div_28s_12ns_16_seq_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW),
                                     .QUOTIENT_WIDTH(QW)) bus ();

    fir_hls_div_28s_12ns_16_seq #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW),
                                  .QUOTIENT_WIDTH(QW)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        longint a;
        longint b;
        longint q;
        longint r;
        bit     ovf;
        bit     dz;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint rem_visible(input longint r);
`ifdef FIR_HLS_DIV_REM_EN
        return r;
`else
        return 0 * r;
`endif
    endfunction

    // Reference: truncating division, remainder follows dividend, then clamp.
    function automatic void model(input longint a, input longint b, output longint q,
                                  output longint r, output bit ovf, output bit dz);
        dz  = (b == 0);
        ovf = 1'b0;
        r   = 0;
        if (dz) begin
            q = (a < 0) ? QMIN : QMAX;
        end else begin
            q = a / b;
            r = a % b;
            if (q > QMAX) begin q = QMAX; ovf = 1'b1; end
            else if (q < QMIN) begin q = QMIN; ovf = 1'b1; end
        end
    endfunction

    task automatic do_op(input string tag, input longint a, input longint b, input longint eq,
                         input longint er, input bit eovf, input bit edz);
        int     lat;
        longint q_got;
        @(negedge ap_clk);
        bus.din0  = DW'(a);
        bus.din1  = VW'(b);
        bus.start = 1'b1;
        @(posedge ap_clk); #1;
        bus.start = 1'b0;
        check({tag, " busy"}, longint'(bus.busy), 1);
        lat = 0;
        while (bus.dout_vld !== 1'b1 && lat < 100) begin
            @(posedge ap_clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, 29);
        q_got = longint'($signed(bus.dout));
        check({tag, " dout"}, q_got, eq);
        check({tag, " dout_rem"}, longint'($signed(bus.dout_rem)), rem_visible(er));
        check({tag, " ovf"}, longint'(bus.ovf), longint'(eovf));
        check({tag, " div_zero"}, longint'(bus.div_zero), longint'(edz));
        @(posedge ap_clk); #1;
        check({tag, " vld pulse"}, longint'(bus.dout_vld), 0);
        check({tag, " dout hold"}, longint'($signed(bus.dout)), eq);
        check({tag, " busy idle"}, longint'(bus.busy), 0);
    endtask

    initial begin
        logic signed [DW-1:0] ra;
        logic [VW-1:0]        rb;
        longint eq, er;
        bit     eovf, edz;
        int     first, second, pulses, cyc;

        tbl[0] = '{1000, 7, 142, 6, 1'b0, 1'b0};
        tbl[1] = '{-1000, 7, -142, -6, 1'b0, 1'b0};
        tbl[2] = '{134217727, 1, 32767, 0, 1'b1, 1'b0};
        tbl[3] = '{-134217728, 4095, -32768, -8, 1'b1, 1'b0};
        tbl[4] = '{5, 0, 32767, 0, 1'b0, 1'b1};
        tbl[5] = '{-5, 0, -32768, 0, 1'b0, 1'b1};
        tbl[6] = '{-131072, 4, -32768, 0, 1'b0, 1'b0};
        tbl[7] = '{131068, 4, 32767, 0, 1'b0, 1'b0};
        tbl[8] = '{131072, 4, 32767, 0, 1'b1, 1'b0};
        tbl[9] = '{-131077, 4, -32768, -1, 1'b1, 1'b0};

        ap_rst    = 1'b1;
        bus.start = 1'b0;
        bus.din0  = '0;
        bus.din1  = '0;
        #2;
        check("reset busy", longint'(bus.busy), 0);
        check("reset vld", longint'(bus.dout_vld), 0);
        check("reset dout", longint'(bus.dout), 0);
        check("reset rem", longint'(bus.dout_rem), 0);
        check("reset ovf", longint'(bus.ovf), 0);
        check("reset dz", longint'(bus.div_zero), 0);
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                  tbl[i].ovf, tbl[i].dz);

        for (int i = 0; i < 40; i++) begin
            ra = DW'($urandom);
            if (i % 3 == 0) ra = ra >>> 10;
            rb = VW'($urandom);
            if (i % 7 == 0) rb = '0;
            model(longint'(ra), longint'(rb), eq, er, eovf, edz);
            do_op($sformatf("rnd%0d", i), longint'(ra), longint'(rb), eq, er, eovf, edz);
        end

        // Start during CALC must be ignored, with a single result pulse.
        @(negedge ap_clk);
        bus.din0 = DW'(1000); bus.din1 = VW'(7); bus.start = 1'b1;
        @(posedge ap_clk); #1;
        bus.start = 1'b0;
        first = -1; pulses = 0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge ap_clk); #1;
            if (i == 10) begin bus.din0 = DW'(-5); bus.din1 = VW'(3); bus.start = 1'b1; end
            if (i == 11) bus.start = 1'b0;
            if (bus.dout_vld === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    check("ign dout", longint'($signed(bus.dout)), 142);
                end
            end
        end
        check("ign latency", first, 29);
        check("ign pulses", pulses, 1);

        // Start held high: back-to-back spacing, FIX-cycle start not taken.
        @(negedge ap_clk);
        bus.din0 = DW'(-1000); bus.din1 = VW'(7); bus.start = 1'b1;
        first = -1; second = -1; cyc = 0;
        repeat (75) begin
            @(posedge ap_clk); #1;
            cyc++;
            if (bus.dout_vld === 1'b1) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
        end
        bus.start = 1'b0;
        check("b2b first", first, 30);
        check("b2b period", second - first, 30);
        check("b2b dout", longint'($signed(bus.dout)), -142);
        cyc = 0;
        while (bus.busy !== 1'b0 && cyc < 60) begin @(posedge ap_clk); #1; cyc++; end
        check("b2b drain", longint'(bus.busy), 0);
        repeat (2) @(posedge ap_clk);

        // Reset in the middle of CALC aborts the operation at once.
        @(negedge ap_clk);
        bus.din0 = DW'(1000); bus.din1 = VW'(7); bus.start = 1'b1;
        @(posedge ap_clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge ap_clk);
        #3 ap_rst = 1'b1;
        #1;
        check("abort busy", longint'(bus.busy), 0);
        check("abort vld", longint'(bus.dout_vld), 0);
        check("abort dout", longint'(bus.dout), 0);
        check("abort dz", longint'(bus.div_zero), 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        bus.din0 = DW'(-1000); bus.din1 = VW'(7); bus.start = 1'b1;
        @(posedge ap_clk); #1;
        bus.start = 1'b0;
        check("post-reset accept", longint'(bus.busy), 1);
        first = -1; pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge ap_clk); #1;
            if (bus.dout_vld === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    check("post-reset dout", longint'($signed(bus.dout)), -142);
                end
            end
        end
        check("post-reset latency", first, 29);
        check("post-reset pulses", pulses, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
